// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants shared by the VGA timing blocks.
package vga_timing_pkg;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int DEF_CLK_DIV   = 2;

    localparam int H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel strobe: registered p_tick, high one clk in every CLK_DIV; first tick in cycle CLK_DIV-1.
// Latency: none beyond the register; backpressure: none, free-running.
module pixel_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic p_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;

    // p_tick is registered so it is low during reset even when CLK_DIV is 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            p_tick  <= 1'b0;
        end else begin
            p_tick  <= (div_cnt == DIV_LAST);
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: counters, active-low syncs, video_on, frame_start; outputs registered, no backpressure.
// VGA_SYNC_ROM_ALIGN_EN delays hsync/vsync/video_on by one pixel period to line up with a synchronous font ROM.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int CLK_DIV   = DEF_CLK_DIV
) (
    input  logic   clk,
    input  logic   rst_n,
    output logic   p_tick,
    output coord_t pixel_x,
    output coord_t pixel_y,
    output logic   video_on,
    output logic   hsync,
    output logic   vsync,
    output logic   frame_start
);

    localparam int HT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int VT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_LAST   = coord_t'(HT - 1);
    localparam coord_t V_LAST   = coord_t'(VT - 1);
    localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
    localparam coord_t HS_FIRST = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_LAST  = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_LAST  = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .p_tick (p_tick)
    );

    coord_t x_nxt;
    coord_t y_nxt;
    logic   hs_nxt;
    logic   vs_nxt;
    logic   von_nxt;

    always_comb begin
        x_nxt = pixel_x;
        y_nxt = pixel_y;
        if (pixel_x == H_LAST) begin
            x_nxt = '0;
            y_nxt = (pixel_y == V_LAST) ? '0 : pixel_y + coord_t'(1);
        end else begin
            x_nxt = pixel_x + coord_t'(1);
        end
        hs_nxt  = !((x_nxt >= HS_FIRST) && (x_nxt <= HS_LAST));
        vs_nxt  = !((y_nxt >= VS_FIRST) && (y_nxt <= VS_LAST));
        von_nxt = (x_nxt < H_VIS) && (y_nxt < V_VIS);
    end

    logic hs_r;
    logic vs_r;
    logic von_r;

    // Decode is taken from the next position so syncs flip on the same edge as the coordinates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_x     <= H_LAST;
            pixel_y     <= V_LAST;
            hs_r        <= 1'b1;
            vs_r        <= 1'b1;
            von_r       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= p_tick && (x_nxt == '0) && (y_nxt == '0);
            if (p_tick) begin
                pixel_x <= x_nxt;
                pixel_y <= y_nxt;
                hs_r    <= hs_nxt;
                vs_r    <= vs_nxt;
                von_r   <= von_nxt;
            end
        end
    end

`ifdef VGA_SYNC_ROM_ALIGN_EN
    logic hs_d;
    logic vs_d;
    logic von_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_d  <= 1'b1;
            vs_d  <= 1'b1;
            von_d <= 1'b0;
        end else if (p_tick) begin
            hs_d  <= hs_r;
            vs_d  <= vs_r;
            von_d <= von_r;
        end
    end

    assign hsync    = hs_d;
    assign vsync    = vs_d;
    assign video_on = von_d;
`else
    assign hsync    = hs_r;
    assign vsync    = vs_r;
    assign video_on = von_r;
`endif

endmodule
